dbg_cmd_decoder: RTL and testbench



---
 rtl/dbg_pkg.sv | 33 +++
 rtl/dbg_cmd_decoder_if.sv | 30 +++
 rtl/dbg_resp_shifter.sv | 40 ++++
 rtl/dbg_cmd_decoder.sv | 167 ++++++++++++++++
 tb/tb_dbg_cmd_decoder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbg_pkg.sv
// Shared constants for the debug command decoder: protocol opcodes,
// response bytes, FSM state encoding and a counter-width helper.
package dbg_pkg;

  // Command opcodes received from the host
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'

  // Response bytes returned to the host
  localparam logic [7:0] RSP_OK   = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR  = 8'h3F;  // '?'

  // State encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_BUS  = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_ADDR = ST_ADDR,
    S_DATA = ST_DATA,
    S_BUS  = ST_BUS,
    S_RESP = ST_RESP
  } state_t;

  // Bits needed for a counter running 0 .. nbytes-1 (at least one bit)
  function automatic int cnt_bits(input int nbytes);
    return (nbytes < 2) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/dbg_cmd_decoder_if.sv
// Signal bundle between the debug command decoder and its neighbours:
// UART receiver side, debug bus side and UART transmitter side.
// master = the decoder, slave = the surrounding environment.
interface dbg_cmd_decoder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [7:0]        rx_char;
  logic              rx_done;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              overrun;

  modport master (
    input  rx_char, rx_done, bus_rdata, bus_ack, tx_ready,
    output bus_req, bus_we, bus_addr, bus_wdata, tx_data, tx_valid, overrun
  );

  modport slave (
    output rx_char, rx_done, bus_rdata, bus_ack, tx_ready,
    input  bus_req, bus_we, bus_addr, bus_wdata, tx_data, tx_valid, overrun
  );
endinterface

// File: rtl/dbg_resp_shifter.sv
// Response byte shifter: loads up to four bytes (MSB-aligned) plus a byte
// count and presents them one at a time on a valid/ready byte interface.
module dbg_resp_shifter (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_count,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        last_xfer
);
  logic [31:0] data_reg;
  logic [2:0]  cnt_reg;
  logic        valid_reg;
  logic        xfer;

  assign xfer      = valid_reg & tx_ready;
  assign last_xfer = xfer & (cnt_reg == 3'd1);
  assign tx_data   = data_reg[31:24];
  assign tx_valid  = valid_reg;

  // Load a new response, or step to the next byte on each accepted transfer
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      data_reg  <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load && (load_count != 3'd0)) begin
      data_reg  <= load_data;
      cnt_reg   <= load_count;
      valid_reg <= 1'b1;
    end else if (xfer) begin
      data_reg  <= data_reg << 8;
      cnt_reg   <= cnt_reg - 3'd1;
      valid_reg <= (cnt_reg != 3'd1);
    end
  end
endmodule

// File: rtl/dbg_cmd_decoder.sv
// Debug command decoder: parses 'R'/'W' packets from the UART receiver,
// runs one debug bus transaction per packet and returns the response bytes
// through the transmitter handshake.
module dbg_cmd_decoder
  import dbg_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16000000,
  parameter int TO_BITS = 24
) (
  input logic               clk,
  input logic               n_rst,
  dbg_cmd_decoder_if.master dbg
);
  localparam int NA = ADDR_W / 8;
  localparam int ND = DATA_W / 8;
  localparam int CW = cnt_bits((NA > ND) ? NA : ND);
  localparam logic [CW-1:0]      NA_LAST = CW'(NA - 1);
  localparam logic [CW-1:0]      ND_LAST = CW'(ND - 1);
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);
  localparam logic [2:0]         ND_CNT  = 3'(ND);

  state_t              state_reg, state_next;
  logic                rx_done_q_reg;
  logic [CW-1:0]       byte_cnt_reg;
  logic [TO_BITS-1:0]  to_cnt_reg;
  logic                bus_req_reg;
  logic                bus_we_reg;
  logic [ADDR_W-1:0]   bus_addr_reg;
  logic [DATA_W-1:0]   bus_wdata_reg;
  logic                overrun_reg;

  logic        strobe;
  logic        in_packet;
  logic        to_hit;
  logic        ack;
  logic        cmd_op;
  logic        last_xfer;
  logic        rsp_load;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_count;
  logic [31:0] rdata_aligned;

  // One byte per rising edge of the receiver's done level
  assign strobe        = dbg.rx_done & ~rx_done_q_reg;
  assign in_packet     = (state_reg == S_ADDR) || (state_reg == S_DATA);
  assign to_hit        = in_packet && (to_cnt_reg == TO_LAST);
  // An ack with no request outstanding is ignored
  assign ack           = dbg.bus_ack & bus_req_reg;
  assign cmd_op        = (dbg.rx_char == OP_READ) || (dbg.rx_char == OP_WRITE);
  assign rdata_aligned = 32'(dbg.bus_rdata) << (32 - DATA_W);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!n_rst) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next state and response-load decode; a strobe beats a same-cycle timeout
  always_comb begin
    state_next = state_reg;
    rsp_load   = 1'b0;
    rsp_data   = '0;
    rsp_count  = '0;
    case (state_reg)
      S_IDLE: begin
        if (strobe) begin
          if (cmd_op) begin
            state_next = S_ADDR;
          end else begin
            state_next = S_RESP;
            rsp_load   = 1'b1;
            rsp_data   = {RSP_ERR, 24'h0};
            rsp_count  = 3'd1;
          end
        end
      end
      S_ADDR: begin
        if (strobe) begin
          if (byte_cnt_reg == NA_LAST) state_next = bus_we_reg ? S_DATA : S_BUS;
        end else if (to_hit) begin
          state_next = S_IDLE;
        end
      end
      S_DATA: begin
        if (strobe) begin
          if (byte_cnt_reg == ND_LAST) state_next = S_BUS;
        end else if (to_hit) begin
          state_next = S_IDLE;
        end
      end
      S_BUS: begin
        if (ack) begin
          state_next = S_RESP;
          rsp_load   = 1'b1;
          rsp_data   = bus_we_reg ? {RSP_OK, 24'h0} : rdata_aligned;
          rsp_count  = bus_we_reg ? 3'd1 : ND_CNT;
        end
      end
      S_RESP: begin
        if (last_xfer) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Packet datapath: field shifting, byte/timeout counters, bus request, overrun
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rx_done_q_reg <= 1'b1;
      byte_cnt_reg  <= '0;
      to_cnt_reg    <= '0;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      rx_done_q_reg <= dbg.rx_done;
      bus_req_reg   <= (state_next == S_BUS);

      if (strobe || !in_packet || to_hit) to_cnt_reg <= '0;
      else                                to_cnt_reg <= to_cnt_reg + TO_BITS'(1);

      if (strobe && ((state_reg == S_BUS) || (state_reg == S_RESP))) overrun_reg <= 1'b1;

      if (strobe) begin
        case (state_reg)
          S_IDLE: begin
            if (cmd_op) begin
              bus_we_reg   <= (dbg.rx_char == OP_WRITE);
              byte_cnt_reg <= '0;
            end
          end
          S_ADDR: begin
            bus_addr_reg <= (bus_addr_reg << 8) | ADDR_W'(dbg.rx_char);
            byte_cnt_reg <= (byte_cnt_reg == NA_LAST) ? '0 : byte_cnt_reg + CW'(1);
          end
          S_DATA: begin
            bus_wdata_reg <= (bus_wdata_reg << 8) | DATA_W'(dbg.rx_char);
            byte_cnt_reg  <= (byte_cnt_reg == ND_LAST) ? '0 : byte_cnt_reg + CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  dbg_resp_shifter u_resp (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (rsp_load),
    .load_data  (rsp_data),
    .load_count (rsp_count),
    .tx_data    (dbg.tx_data),
    .tx_valid   (dbg.tx_valid),
    .tx_ready   (dbg.tx_ready),
    .last_xfer  (last_xfer)
  );

  assign dbg.bus_req   = bus_req_reg;
  assign dbg.bus_we    = bus_we_reg;
  assign dbg.bus_addr  = bus_addr_reg;
  assign dbg.bus_wdata = bus_wdata_reg;
  assign dbg.overrun   = overrun_reg;
endmodule

// File: tb/tb_dbg_cmd_decoder.sv
// Scoreboard bench for dbg_cmd_decoder: stimulus pushes expected bus
// transactions and tx bytes; a bus responder and a tx monitor pop and compare.
module tb_dbg_cmd_decoder;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } bus_t;

  logic clk = 1'b0;
  logic n_rst;

  int total = 0;
  int bad   = 0;

  bus_t       bus_exp[$];
  logic [7:0] tx_exp[$];

  bit ack_en       = 1'b1;
  bit late_ack_req = 1'b0;
  int stall_req    = 0;
  int stall_cnt    = 0;

  dbg_cmd_decoder_if #(.ADDR_W(32), .DATA_W(32)) dbg ();

  dbg_cmd_decoder #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (100),
    .TO_BITS (24)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .dbg   (dbg.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bus_req"},   dbg.bus_req,   0);
    chk({tag, "_bus_we"},    dbg.bus_we,    0);
    chk({tag, "_bus_addr"},  dbg.bus_addr,  0);
    chk({tag, "_bus_wdata"}, dbg.bus_wdata, 0);
    chk({tag, "_tx_valid"},  dbg.tx_valid,  0);
    chk({tag, "_tx_data"},   dbg.tx_data,   0);
    chk({tag, "_overrun"},   dbg.overrun,   0);
  endtask

  // Starts and ends on a falling edge; optionally checks bus_req right after the strobe edge
  task automatic send_byte(input logic [7:0] b, input int hold, input bit chk_req);
    dbg.rx_char = b;
    dbg.rx_done = 1'b1;
    if (chk_req) begin
      @(posedge clk);
      #1;
      chk("bus_req_latency", dbg.bus_req, 1);
    end
    repeat (hold) @(negedge clk);
    dbg.rx_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_read(input logic [31:0] addr, input int hold);
    send_byte(8'h52, hold, 1'b0);
    for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8], hold, i == 0);
  endtask

  task automatic send_write(input logic [31:0] addr, input logic [31:0] data, input int hold);
    send_byte(8'h57, hold, 1'b0);
    for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8], hold, 1'b0);
    for (int i = 3; i >= 0; i--) send_byte(data[i*8 +: 8], hold, i == 0);
  endtask

  task automatic exp_read(input logic [31:0] addr, input logic [31:0] rdata);
    bus_t e;
    e.we = 1'b0; e.addr = addr; e.wdata = '0; e.rdata = rdata;
    bus_exp.push_back(e);
    for (int i = 3; i >= 0; i--) tx_exp.push_back(rdata[i*8 +: 8]);
  endtask

  task automatic exp_write(input logic [31:0] addr, input logic [31:0] wdata);
    bus_t e;
    e.we = 1'b1; e.addr = addr; e.wdata = wdata; e.rdata = '0;
    bus_exp.push_back(e);
    tx_exp.push_back(8'h4B);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((tx_exp.size() != 0 || bus_exp.size() != 0 || dbg.tx_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL %s_drain: got pending bus=%0d tx=%0d want 0 0", name, bus_exp.size(), tx_exp.size());
    end
  endtask

  // Bus responder and bus-side checker
  initial begin
    bus_t e;
    dbg.bus_ack   = 1'b0;
    dbg.bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (late_ack_req) begin
        dbg.bus_ack = 1'b1;
        @(negedge clk);
        dbg.bus_ack  = 1'b0;
        late_ack_req = 1'b0;
      end else if (dbg.bus_req && ack_en) begin
        if (bus_exp.size() == 0) begin
          e.we = 1'b0; e.addr = '0; e.wdata = '0; e.rdata = '0;
          total++;
          bad++;
          $display("FAIL bus_unexpected: got bus_req addr=%0h want no request", dbg.bus_addr);
        end else begin
          e = bus_exp.pop_front();
          chk("bus_we", dbg.bus_we, e.we);
          chk("bus_addr", dbg.bus_addr, e.addr);
          if (e.we) chk("bus_wdata", dbg.bus_wdata, e.wdata);
        end
        repeat (2) @(negedge clk);
        chk("bus_req_hold", dbg.bus_req, 1);
        dbg.bus_rdata = e.rdata;
        dbg.bus_ack   = 1'b1;
        @(negedge clk);
        dbg.bus_ack = 1'b0;
        chk("bus_req_drop", dbg.bus_req, 0);
        chk("tx_valid_after_ack", dbg.tx_valid, 1);
      end
    end
  end

  // Transmitter model and tx-side checker
  initial begin
    bit         hold_prev = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] e;
    dbg.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_cnt > 0) begin
        dbg.tx_ready = 1'b0;
        stall_cnt--;
      end else begin
        dbg.tx_ready = 1'b1;
      end
      if (hold_prev) begin
        chk("tx_hold_valid", dbg.tx_valid, 1);
        chk("tx_hold_data", dbg.tx_data, prev_data);
      end
      if (dbg.tx_valid && dbg.tx_ready) begin
        if (tx_exp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected: got %0h want no byte", dbg.tx_data);
        end else begin
          e = tx_exp.pop_front();
          chk("tx_byte", dbg.tx_data, e);
          $display("tx byte %02h (expected %02h)", dbg.tx_data, e);
        end
        if (stall_req > 0) begin
          stall_cnt = stall_req;
          stall_req = 0;
        end
      end
      hold_prev = dbg.tx_valid && !dbg.tx_ready;
      prev_data = dbg.tx_data;
    end
  end

  // Stimulus
  initial begin
    int n;
    n_rst       = 1'b0;
    dbg.rx_done = 1'b1;
    dbg.rx_char = 8'h41;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    n_rst = 1'b1;
    // rx_done already high at release must not produce a byte
    repeat (10) @(negedge clk);
    chk("no_byte_at_release_tx", dbg.tx_valid, 0);
    chk("no_byte_at_release_req", dbg.bus_req, 0);
    dbg.rx_done = 1'b0;
    repeat (2) @(negedge clk);

    // Write
    exp_write(32'h0000_1000, 32'hDEAD_BEEF);
    send_write(32'h0000_1000, 32'hDEAD_BEEF, 1);
    drain("write");

    // Read with a 50-cycle tx stall and a byte arriving during RESP
    chk("overrun_clear", dbg.overrun, 0);
    exp_read(32'h0000_0004, 32'h1234_5678);
    stall_req = 50;
    send_read(32'h0000_0004, 1);
    n = 0;
    while (stall_cnt == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall_started", (n < 200), 1);
    send_byte(8'h00, 1, 1'b0);
    chk("overrun_set", dbg.overrun, 1);
    drain("read_stall");

    // Unknown opcode then a normal read
    tx_exp.push_back(8'h3F);
    send_byte(8'h41, 1, 1'b0);
    drain("unknown");
    exp_read(32'h0000_0000, 32'hCAFE_F00D);
    send_read(32'h0000_0000, 1);
    drain("read_after_unknown");

    // Timeout mid-packet, then a full read
    send_byte(8'h57, 1, 1'b0);
    send_byte(8'h00, 1, 1'b0);
    send_byte(8'h00, 1, 1'b0);
    repeat (101) @(negedge clk);
    chk("timeout_no_req", dbg.bus_req, 0);
    chk("timeout_no_tx", dbg.tx_valid, 0);
    exp_read(32'h0000_0008, 32'h0BAD_C0DE);
    send_read(32'h0000_0008, 1);
    drain("read_after_timeout");

    // Long rx_done levels and an inter-byte gap just under the timeout
    exp_write(32'h0000_2000, 32'h1122_3344);
    send_byte(8'h57, 20, 1'b0);
    send_byte(8'h00, 20, 1'b0);
    send_byte(8'h00, 20, 1'b0);
    repeat (70) @(negedge clk);
    send_byte(8'h20, 20, 1'b0);
    send_byte(8'h00, 20, 1'b0);
    send_byte(8'h11, 20, 1'b0);
    send_byte(8'h22, 20, 1'b0);
    send_byte(8'h33, 20, 1'b0);
    send_byte(8'h44, 20, 1'b1);
    drain("slow_write");

    // Reset while a read is waiting for ack; a late ack must be ignored
    ack_en = 1'b0;
    send_read(32'h0000_0010, 1);
    chk("pre_reset_req", dbg.bus_req, 1);
    chk("pre_reset_addr", dbg.bus_addr, 32'h10);
    chk("pre_reset_we", dbg.bus_we, 0);
    n_rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midbus");
    n_rst        = 1'b1;
    late_ack_req = 1'b1;
    repeat (10) @(negedge clk);
    chk("late_ack_no_req", dbg.bus_req, 0);
    chk("late_ack_no_tx", dbg.tx_valid, 0);
    ack_en = 1'b1;
    exp_read(32'h0000_0014, 32'h55AA_33CC);
    send_read(32'h0000_0014, 1);
    drain("read_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "time limit");
  end

endmodule
